// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO slave with per-bit direction, input synchroniser and sticky
// edge-detect interrupts (W1C status, set wins over a same-cycle clear).
module ahb_gpio_irq #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic             HREADY,
    output logic             HREADYOUT,
    input  logic [31:0]      HWDATA,
    output logic [31:0]      HRDATA,
    input  logic [WIDTH-1:0] GPIOIN,
    output logic [WIDTH-1:0] GPIOOUT,
    output logic [WIDTH-1:0] GPIOOE,
    output logic             IRQ
);

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_EN   = 3'd2;
    localparam logic [2:0] A_TYPE = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;

    logic [2:0]       r_addr;
    logic             r_write;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_en;
    logic [WIDTH-1:0] r_type;
    logic [WIDTH-1:0] r_stat;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_sync_in = r_sync[SYNC_STAGES-1];
    assign w_wdata   = HWDATA[WIDTH-1:0];
    assign w_wr      = r_valid & r_write;
    assign w_set     = ((w_sync_in & ~r_prev & ~r_type) |
                        (~w_sync_in & r_prev & r_type)) & ~r_dir;
    assign w_clr     = (w_wr && r_addr == A_STAT) ? w_wdata : '0;
    assign w_unused  = &{1'b0, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
        end else if (HSEL && HREADY && HTRANS[1]) begin
            r_valid <= 1'b1;
            r_write <= HWRITE;
            r_addr  <= HADDR[4:2];
        end else begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: the synchroniser array is reset explicitly so sync_in and prev_in start equal (no edge out of reset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= GPIOIN;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_sync_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_dir  <= '0;
            r_en   <= '0;
            r_type <= '0;
            r_stat <= '0;
        end else begin
            r_stat <= (r_stat & ~w_clr) | w_set;
            if (w_wr) begin
                case (r_addr)
                    A_DATA:  r_out  <= w_wdata;
                    A_DIR:   r_dir  <= w_wdata;
                    A_EN:    r_en   <= w_wdata;
                    A_TYPE:  r_type <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the default assignment first keeps this mux free of inferred latches.
    always_comb begin
        w_rdata = '0;
        if (r_valid && !r_write) begin
            case (r_addr)
                A_DATA:  w_rdata[WIDTH-1:0] = (r_out & r_dir) | (w_sync_in & ~r_dir);
                A_DIR:   w_rdata[WIDTH-1:0] = r_dir;
                A_EN:    w_rdata[WIDTH-1:0] = r_en;
                A_TYPE:  w_rdata[WIDTH-1:0] = r_type;
                A_STAT:  w_rdata[WIDTH-1:0] = r_stat;
                default: ;
            endcase
        end
    end

    assign HRDATA    = w_rdata;
    assign HREADYOUT = 1'b1;
    assign GPIOOUT   = r_out;
    assign GPIOOE    = r_dir;
    assign IRQ       = |(r_stat & r_en);

endmodule
